// File: rtl/flow_led_sequencer.sv
// One-hot LED chaser driven by rising edges of the blink generator output.
// Supports rotate-left, rotate-right, ping-pong and hold, with registered outputs.
module flow_led_sequencer #(
  parameter int N_LED = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Step_in,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  output logic [N_LED-1:0] LED_out,
  output logic [3:0]       Pos,
  output logic             Step_pulse,
  output logic             Dir
);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam logic [3:0] POS_LAST = 4'(N_LED - 1);

  logic             s1_q, s2_q, s3_q;
  logic             step;
  logic             adv;
  logic [3:0]       pos_q, pos_d;
  dir_t             dir_q, dir_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             pulse_q, pulse_d;

  assign step    = s2_q & ~s3_q;
  assign adv     = step & Enable;
  assign pulse_d = adv;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (adv) begin
      case (Mode)
        2'b00: pos_d = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;
        2'b01: pos_d = (pos_q == 4'd0) ? POS_LAST : pos_q - 4'd1;
        2'b10: begin
          // Endpoints are visited once per bounce: turn around on the step away.
          if (dir_q == UP) begin
            if (pos_q == POS_LAST) begin
              pos_d = POS_LAST - 4'd1;
              dir_d = DOWN;
            end else begin
              pos_d = pos_q + 4'd1;
            end
          end else begin
            if (pos_q == 4'd0) begin
              pos_d = 4'd1;
              dir_d = UP;
            end else begin
              pos_d = pos_q - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_LED; gi++) begin : g_led
    assign led_d[gi] = (pos_d == 4'(gi));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pos_q   <= 4'd0;
      dir_q   <= UP;
      led_q   <= N_LED'(1);
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= Step_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      pulse_q <= pulse_d;
    end
  end

  assign LED_out    = led_q;
  assign Pos        = pos_q;
  assign Dir        = dir_q;
  assign Step_pulse = pulse_q;

endmodule

// File: tb/tb_flow_led_sequencer.sv
// Scoreboard bench for flow_led_sequencer: N_LED=4 main instance plus an N_LED=2 ping-pong instance.
module tb_flow_led_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       step_in = 1'b0;
  logic       step2 = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;

  logic [3:0] led;
  logic [3:0] pos;
  logic       pulse, dir;
  logic [1:0] led2;
  logic [3:0] pos2;
  logic       pulse2, dir2;

  always #5 clk = ~clk;

  flow_led_sequencer #(.N_LED(4)) dut (
    .CLK(clk), .RSTn(rstn), .Step_in(step_in), .Enable(en), .Mode(mode),
    .LED_out(led), .Pos(pos), .Step_pulse(pulse), .Dir(dir)
  );

  flow_led_sequencer #(.N_LED(2)) dut2 (
    .CLK(clk), .RSTn(rstn), .Step_in(step2), .Enable(1'b1), .Mode(2'b10),
    .LED_out(led2), .Pos(pos2), .Step_pulse(pulse2), .Dir(dir2)
  );

  typedef struct packed {
    logic [3:0]  pos;
    logic        dir;
    logic [31:0] cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   cyc = 0;
  int   m_pos = 0, m_dir = 0, m2_pos = 0, m2_dir = 0;
  int   n_cmp = 0, n_err = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one advance.
  task automatic model_step(input int md, input int n, inout int p, inout int d);
    case (md)
      0: p = (p + 1) % n;
      1: p = (p + n - 1) % n;
      2: begin
        if (d == 0) begin
          if (p == n - 1) begin p = n - 2; d = 1; end
          else p = p + 1;
        end else begin
          if (p == 0) begin p = 1; d = 0; end
          else p = p - 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic push1();
    exp_t e;
    model_step(int'(mode), 4, m_pos, m_dir);
    e.pos = 4'(m_pos);
    e.dir = 1'(m_dir);
    e.cyc = 32'(cyc + 3);
    q1.push_back(e);
  endtask

  task automatic rise(input int hi, input int lo, input bit exp_adv);
    @(negedge clk);
    step_in = 1'b1;
    if (exp_adv) push1();
    repeat (hi) @(negedge clk);
    step_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rise2(input int hi, input int lo);
    exp_t e;
    @(negedge clk);
    step2 = 1'b1;
    model_step(2, 2, m2_pos, m2_dir);
    e.pos = 4'(m2_pos);
    e.dir = 1'(m2_dir);
    e.cyc = 32'(cyc + 3);
    q2.push_back(e);
    repeat (hi) @(negedge clk);
    step2 = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    m_pos = 0; m_dir = 0; m2_pos = 0; m2_dir = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pos"}, 32'(pos), 32'(m_pos));
    check({tag, "_led"}, 32'(led), 32'(1) << m_pos);
    check({tag, "_dir"}, 32'(dir), 32'(m_dir));
  endtask

  always @(negedge clk) begin
    if (pulse === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut_unexpected_pulse", 32'(pulse), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut_pos", 32'(pos), 32'(e1.pos));
        check("dut_led", 32'(led), 32'(1) << e1.pos);
        check("dut_dir", 32'(dir), 32'(e1.dir));
        check("dut_latency", 32'(cyc), e1.cyc);
        $display("step cyc=%0d pos=%0d led=%b dir=%0d", cyc, pos, led, dir);
      end
    end
  end

  always @(negedge clk) begin
    if (pulse2 === 1'b1) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_pulse", 32'(pulse2), 32'd0);
      end else begin
        e2 = q2.pop_front();
        check("dut2_pos", 32'(pos2), 32'(e2.pos));
        check("dut2_led", 32'(led2), 32'(1) << e2.pos);
        check("dut2_dir", 32'(dir2), 32'(e2.dir));
        check("dut2_latency", 32'(cyc), e2.cyc);
        $display("step2 cyc=%0d pos=%0d led=%b dir=%0d", cyc, pos2, led2, dir2);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'd1);
    check("reset_pos", 32'(pos), 32'd0);
    check("reset_pulse", 32'(pulse), 32'd0);
    check("reset_dir", 32'(dir), 32'd0);
    rstn = 1'b1;

    // Rotate-left across the wrap.
    mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 6; i++) rise(10, 10, 1'b1);
    check_state("rotl");

    // Ping-pong from reset.
    do_reset();
    mode = 2'b10;
    for (int i = 0; i < 8; i++) rise(10, 10, 1'b1);
    check_state("pingpong");

    // Disabled edges are ignored.
    en = 1'b0;
    for (int i = 0; i < 3; i++) rise(10, 10, 1'b0);
    check_state("disabled");

    // Re-enable while Step_in is already high: no advance for that edge.
    @(negedge clk); step_in = 1'b1;
    repeat (10) @(negedge clk); en = 1'b1;
    repeat (10) @(negedge clk); step_in = 1'b0;
    repeat (10) @(negedge clk);
    check_state("reenable_high");
    rise(10, 10, 1'b1);

    // Hold mode still pulses.
    mode = 2'b11;
    for (int i = 0; i < 2; i++) rise(10, 10, 1'b1);
    check_state("hold");

    // Enable dropped exactly in the step cycle loses that edge.
    mode = 2'b00;
    @(negedge clk); step_in = 1'b1;
    repeat (2) @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    repeat (8) @(negedge clk); step_in = 1'b0;
    repeat (10) @(negedge clk);
    check_state("en_drop");

    // Mode switching mid-run.
    do_reset();
    mode = 2'b00;
    for (int i = 0; i < 2; i++) rise(10, 10, 1'b1);
    mode = 2'b01;
    for (int i = 0; i < 3; i++) rise(10, 10, 1'b1);
    mode = 2'b10;
    for (int i = 0; i < 2; i++) rise(10, 10, 1'b1);
    check_state("mode_switch");

    // Reset mid-edge discards the pending advance.
    mode = 2'b00;
    @(negedge clk); step_in = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0; step_in = 1'b0;
    m_pos = 0; m_dir = 0;
    #1;
    check("midrst_led", 32'(led), 32'd1);
    check("midrst_pos", 32'(pos), 32'd0);
    check("midrst_pulse", 32'(pulse), 32'd0);
    repeat (3) @(negedge clk); rstn = 1'b1;
    repeat (10) @(negedge clk);
    check_state("midrst_after");

    // Step_in high at reset release counts as one edge.
    @(negedge clk); rstn = 1'b0; step_in = 1'b1;
    m_pos = 0; m_dir = 0;
    @(negedge clk); rstn = 1'b1; push1();
    repeat (20) @(negedge clk); step_in = 1'b0;
    repeat (10) @(negedge clk);
    check_state("high_at_release");

    // Long high time yields exactly one advance.
    rise(3000, 10, 1'b1);
    check_state("long_high");

    // Two-LED ping-pong.
    for (int i = 0; i < 4; i++) rise2(10, 10);
    check("dut2_final_pos", 32'(pos2), 32'(m2_pos));

    repeat (10) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
